// File: rtl/ahb_burst_slave_mem.sv
// AHB-Lite single-port word memory slave.
// Captures an address phase on every edge where hsel_i, hready_o and htrans_i[1] are all high.
// Each legal transfer waits WaitStates cycles, then completes its data phase.
// Illegal transfers get a two-cycle ERROR response and never touch memory.
//
// Optional build macro AHB_SLV_BURST_CHECK_EN adds a burst tracker.
// It checks every SEQ beat against the expected address and the remaining beat count.
// When the macro is undefined, SEQ is decoded exactly like NONSEQ.
//
// Ports:
//   hclk_i     bus clock, rising edge
//   hreset_ni  asynchronous active-low reset
//   hsel_i     slave select
//   haddr_i    byte address
//   htrans_i   IDLE/BUSY/NONSEQ/SEQ
//   hwrite_i   1 write, 0 read
//   hsize_i    transfer size, only word (3'b010) is legal
//   hburst_i   burst type
//   hwdata_i   write data (data phase)
//   hrdata_o   read data, valid while hready_o is high in a read data phase
//   hready_o   transfer done / bus ready
//   hresp_o    2'b00 OKAY, 2'b01 ERROR
module ahb_burst_slave_mem #(
  parameter int unsigned DepthWords = 256,
  parameter logic [31:0] BaseAddr   = 32'h0000_0000,
  parameter int unsigned WaitStates = 0
) (
  input  logic        hclk_i,
  input  logic        hreset_ni,
  input  logic        hsel_i,
  input  logic [31:0] haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  input  logic [2:0]  hburst_i,
  input  logic [31:0] hwdata_i,
  output logic [31:0] hrdata_o,
  output logic        hready_o,
  output logic [1:0]  hresp_o
);

  localparam int unsigned IdxW = $clog2(DepthWords);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic            wr_q;
  logic [3:0]      wcnt_q;
  logic            hready_q;
  logic [1:0]      hresp_q;
  logic [31:0]     hrdata_q;
  logic [31:0]     mem_q [DepthWords];

  logic [31:0]     offset;
  logic [IdxW-1:0] idx;
  logic            in_range;
  logic            capture;
  logic            legal;
  logic            burst_ok;
  logic            bypass;

  assign offset   = haddr_i - BaseAddr;
  assign idx      = offset[IdxW+1:2];
  // Out-of-window addresses are errors; the offset is never wrapped into the array.
  assign in_range = (haddr_i >= BaseAddr) && (offset < (DepthWords << 2));
  assign capture  = hsel_i && hready_q && htrans_i[1];
  assign legal    = in_range && (haddr_i[1:0] == 2'b00) && (hsize_i == 3'b010) && burst_ok;
  // A read captured while the previous write is still finishing must see the new data.
  assign bypass   = (state_q == StData) && wr_q && (idx_q == idx);

  logic unused_offset;
  assign unused_offset = ^{offset[1:0], offset[31:IdxW+2]};

`ifdef AHB_SLV_BURST_CHECK_EN
  logic        trk_open_q;
  logic [31:0] trk_exp_q;
  logic [3:0]  trk_left_q;
  logic [2:0]  trk_burst_q;

  logic        is_seq;
  logic [2:0]  burst_sel;
  logic [31:0] nxt_addr;
  logic [3:0]  left_after;
  logic        open_after;

  always_comb begin
    is_seq    = htrans_i[0];
    burst_sel = is_seq ? trk_burst_q : hburst_i;
    burst_ok  = !is_seq || (trk_open_q && (haddr_i == trk_exp_q));
    case (burst_sel)
      3'b010:  nxt_addr = {haddr_i[31:4], haddr_i[3:0] + 4'd4};
      3'b100:  nxt_addr = {haddr_i[31:5], haddr_i[4:0] + 5'd4};
      3'b110:  nxt_addr = {haddr_i[31:6], haddr_i[5:0] + 6'd4};
      default: nxt_addr = haddr_i + 32'd4;
    endcase
    if (is_seq) begin
      left_after = trk_left_q - 4'd1;
    end else begin
      case (hburst_i)
        3'b010, 3'b011: left_after = 4'd3;
        3'b100, 3'b101: left_after = 4'd7;
        3'b110, 3'b111: left_after = 4'd15;
        default:        left_after = 4'd0;
      endcase
    end
    // INCR never runs out of beats.
    open_after = (burst_sel == 3'b001) || (left_after != 4'd0);
  end

  always_ff @(posedge hclk_i or negedge hreset_ni) begin
    if (!hreset_ni) begin
      trk_open_q  <= 1'b0;
      trk_exp_q   <= '0;
      trk_left_q  <= '0;
      trk_burst_q <= 3'b000;
    end else if (capture) begin
      if (legal) begin
        trk_open_q  <= open_after;
        trk_exp_q   <= nxt_addr;
        trk_left_q  <= left_after;
        trk_burst_q <= burst_sel;
      end else begin
        trk_open_q  <= 1'b0;
      end
    end
  end
`else
  assign burst_ok = 1'b1;

  logic unused_burst;
  assign unused_burst = ^{hburst_i, htrans_i[0]};
`endif

  always_ff @(posedge hclk_i or negedge hreset_ni) begin
    if (!hreset_ni) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      wcnt_q   <= '0;
      hready_q <= 1'b1;
      hresp_q  <= 2'b00;
      hrdata_q <= '0;
    end else begin
      hrdata_q <= '0;
      unique case (state_q)
        StWait: begin
          if (wcnt_q == 4'd0) begin
            state_q  <= StData;
            hready_q <= 1'b1;
            // The preceding write finished at least one edge ago, so memory is current.
            if (!wr_q) hrdata_q <= mem_q[idx_q];
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        StErr1: begin
          state_q  <= StErr2;
          hready_q <= 1'b1;
        end
        default: begin
          // StIdle, StData and StErr2 all present hready high and may accept a new address.
          if (capture && legal) begin
            idx_q   <= idx;
            wr_q    <= hwrite_i;
            hresp_q <= 2'b00;
            if (WaitStates == 0) begin
              state_q  <= StData;
              hready_q <= 1'b1;
              if (!hwrite_i) hrdata_q <= bypass ? hwdata_i : mem_q[idx];
            end else begin
              state_q  <= StWait;
              hready_q <= 1'b0;
              wcnt_q   <= 4'(WaitStates - 1);
            end
          end else if (capture) begin
            state_q  <= StErr1;
            wr_q     <= 1'b0;
            hready_q <= 1'b0;
            hresp_q  <= 2'b01;
          end else begin
            state_q  <= StIdle;
            wr_q     <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= 2'b00;
          end
        end
      endcase
    end
  end

  // No reset: contents survive reset, and a reset mid-phase drops state_q so no write lands.
  always_ff @(posedge hclk_i) begin
    if ((state_q == StData) && wr_q) mem_q[idx_q] <= hwdata_i;
  end

  assign hrdata_o = hrdata_q;
  assign hready_o = hready_q;
  assign hresp_o  = hresp_q;

endmodule

// File: tb/tb_ahb_burst_slave_mem.sv
`timescale 1ns/1ps
module tb_ahb_burst_slave_mem;

  localparam int unsigned Depth = 256;
  localparam logic [31:0] Base  = 32'h0000_0000;
  localparam logic [1:0]  TrIdle   = 2'b00;
  localparam logic [1:0]  TrNonSeq = 2'b10;
  localparam logic [1:0]  TrSeq    = 2'b11;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  burst;
    logic [2:0]  size;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel0, hsel2;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] hrdata0, hrdata2;
  logic        hready0, hready2;
  logic [1:0]  hresp0, hresp2;

  int          tgt;
  int          checks = 0;
  int          errors = 0;
  beat_t       bq[$];
  logic [31:0] mdl_mem [2][Depth];

`ifdef AHB_SLV_BURST_CHECK_EN
  bit          trk_open [2];
  logic [31:0] trk_exp  [2];
  int          trk_left [2];
  logic [2:0]  trk_burst[2];
`endif

  always #5 clk = ~clk;

  ahb_burst_slave_mem #(.DepthWords(Depth), .BaseAddr(Base), .WaitStates(0)) u_dut0 (
    .hclk_i(clk), .hreset_ni(rst_n), .hsel_i(hsel0), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst), .hwdata_i(hwdata),
    .hrdata_o(hrdata0), .hready_o(hready0), .hresp_o(hresp0)
  );

  ahb_burst_slave_mem #(.DepthWords(Depth), .BaseAddr(Base), .WaitStates(2)) u_dut2 (
    .hclk_i(clk), .hreset_ni(rst_n), .hsel_i(hsel2), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst), .hwdata_i(hwdata),
    .hrdata_o(hrdata2), .hready_o(hready2), .hresp_o(hresp2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (target %0d)", tag, obs, exp, tgt);
    end
  endtask

  function automatic logic cur_ready();
    return (tgt == 1) ? hready2 : hready0;
  endfunction

  function automatic logic [1:0] cur_resp();
    return (tgt == 1) ? hresp2 : hresp0;
  endfunction

  function automatic logic [31:0] cur_rdata();
    return (tgt == 1) ? hrdata2 : hrdata0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - Base) >> 2);
  endfunction

  task automatic model_reset();
`ifdef AHB_SLV_BURST_CHECK_EN
    for (int t = 0; t < 2; t++) begin
      trk_open[t] = 1'b0;
      trk_left[t] = 0;
    end
`endif
  endtask

`ifdef AHB_SLV_BURST_CHECK_EN
  // Beats in a burst; 0 means unlimited (INCR).
  function automatic int burst_len(input logic [2:0] br);
    case (br)
      3'b000:         return 1;
      3'b001:         return 0;
      3'b010, 3'b011: return 4;
      3'b100, 3'b101: return 8;
      default:        return 16;
    endcase
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] br);
    logic [31:0] bs;
    logic [31:0] blk;
    case (br)
      3'b010:  bs = 32'd16;
      3'b100:  bs = 32'd32;
      3'b110:  bs = 32'd64;
      default: bs = 32'd0;
    endcase
    if (bs == 32'd0) return a + 32'd4;
    blk = a - (a % bs);
    return blk + ((a - blk + 32'd4) % bs);
  endfunction
`endif

  // 0: no transfer, 1: legal transfer, 2: ERROR response expected.
  function automatic int model_capture(input beat_t b);
    bit ok;
    longint unsigned a;
    if (b.trans[1] == 1'b0) return 0;
    a  = longint'(b.addr);
    ok = (a >= longint'(Base)) && (a < longint'(Base) + 4 * longint'(Depth)) &&
         (b.addr[1:0] == 2'b00) && (b.size == 3'b010);
`ifdef AHB_SLV_BURST_CHECK_EN
    if (b.trans == TrSeq) ok = ok && trk_open[tgt] && (b.addr == trk_exp[tgt]);
    if (ok) begin
      if (b.trans == TrNonSeq) begin
        trk_burst[tgt] = b.burst;
        trk_left[tgt]  = (burst_len(b.burst) == 0) ? -1 : burst_len(b.burst) - 1;
      end else if (trk_left[tgt] > 0) begin
        trk_left[tgt]--;
      end
      trk_exp[tgt]  = next_addr(b.addr, trk_burst[tgt]);
      trk_open[tgt] = (trk_left[tgt] != 0);
    end else begin
      trk_open[tgt] = 1'b0;
    end
`endif
    return ok ? 1 : 2;
  endfunction

  task automatic add(input logic [31:0] a, input logic [1:0] tr, input logic wr,
                     input logic [2:0] br, input logic [2:0] sz, input logic [31:0] d);
    beat_t b;
    b.addr = a; b.trans = tr; b.wr = wr; b.burst = br; b.size = sz; b.data = d;
    bq.push_back(b);
  endtask

  task automatic drive_addr(input int i, input int n);
    if (i < n) begin
      haddr = bq[i].addr; htrans = bq[i].trans; hwrite = bq[i].wr;
      hburst = bq[i].burst; hsize = bq[i].size;
    end else begin
      haddr = 32'h0; htrans = TrIdle; hwrite = 1'b0; hburst = 3'b000; hsize = 3'b010;
    end
  endtask

  // Plays the queued beats as a pipelined AHB master and checks every data phase.
  task automatic run_beats();
    int n, cur, nxt, waits, guard, limit, st, ews;
    logic rdy, prev_rdy;
    n = bq.size(); cur = -1; nxt = 0; waits = 0; guard = 0; st = 0;
    limit = 20 * n + 20;
    ews   = (tgt == 1) ? 2 : 0;
    hsel0 = (tgt == 0);
    hsel2 = (tgt == 1);
    drive_addr(nxt, n);
    prev_rdy = cur_ready();
    check("ready_before_burst", 32'(prev_rdy), 32'd1);
    while ((cur >= 0 || nxt < n) && guard < limit) begin
      @(posedge clk); #1;
      guard++;
      if (prev_rdy) begin
        if (cur >= 0 && st == 1 && bq[cur].wr) mdl_mem[tgt][widx(bq[cur].addr)] = bq[cur].data;
        if (nxt < n) begin
          cur = nxt;
          st  = model_capture(bq[cur]);
          nxt++;
        end else begin
          cur = -1;
        end
        waits = 0;
        drive_addr(nxt, n);
        hwdata = (cur >= 0) ? bq[cur].data : 32'h0;
      end
      rdy = cur_ready();
      if (cur >= 0) begin
        if (!rdy) begin
          waits++;
          check("wait_resp", 32'(cur_resp()), (st == 2) ? 32'd1 : 32'd0);
        end else begin
          check("wait_count", 32'(waits), (st == 1) ? 32'(ews) : ((st == 2) ? 32'd1 : 32'd0));
          check("resp", 32'(cur_resp()), (st == 2) ? 32'd1 : 32'd0);
          if (st == 1 && !bq[cur].wr)
            check("rdata", cur_rdata(), mdl_mem[tgt][widx(bq[cur].addr)]);
        end
      end
      prev_rdy = rdy;
    end
    check("burst_done_in_time", 32'(guard < limit), 32'd1);
    bq.delete();
  endtask

  initial begin
    int kind, w, sub;
    rst_n = 1'b0; hsel0 = 1'b0; hsel2 = 1'b0; haddr = '0; htrans = TrIdle; hwrite = 1'b0;
    hsize = 3'b010; hburst = 3'b000; hwdata = '0; tgt = 0;
    model_reset();

    #12;
    check("rst_hready0", 32'(hready0), 32'd1);
    check("rst_hresp0", 32'(hresp0), 32'd0);
    check("rst_hrdata0", hrdata0, 32'd0);
    check("rst_hready2", 32'(hready2), 32'd1);
    check("rst_hresp2", 32'(hresp2), 32'd0);
    check("rst_hrdata2", hrdata2, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill both memories so every later read has a known value.
    for (int t = 0; t < 2; t++) begin
      tgt = t;
      for (int i = 0; i < int'(Depth); i++)
        add(Base + 32'(i * 4), (i == 0) ? TrNonSeq : TrSeq, 1'b1, 3'b001, 3'b010, $urandom);
      run_beats();
    end

    // Single write then single read, no wait states.
    tgt = 0;
    add(32'h34, TrNonSeq, 1'b1, 3'b000, 3'b010, 32'h1111_1134);
    add(32'h0,  TrIdle,   1'b0, 3'b000, 3'b010, 32'h0);
    add(32'h34, TrNonSeq, 1'b0, 3'b000, 3'b010, 32'h0);
    run_beats();

    // INCR4 write directly followed by a read of the last beat's word.
    for (int j = 0; j < 4; j++)
      add(32'h40 + 32'(j * 4), (j == 0) ? TrNonSeq : TrSeq, 1'b1, 3'b011, 3'b010, 32'hA0 + 32'(j));
    add(32'h4C, TrNonSeq, 1'b0, 3'b000, 3'b010, 32'h0);
    run_beats();

    // Two wait states.
    tgt = 1;
    add(32'h34, TrNonSeq, 1'b1, 3'b000, 3'b010, 32'h1111_1134);
    add(32'h0,  TrIdle,   1'b0, 3'b000, 3'b010, 32'h0);
    add(32'h34, TrNonSeq, 1'b0, 3'b000, 3'b010, 32'h0);
    run_beats();

    // Out-of-range and unaligned writes, then confirm memory was untouched.
    tgt = 0;
    add(32'h400, TrNonSeq, 1'b1, 3'b000, 3'b010, 32'hBAD0_0400);
    add(32'h35,  TrNonSeq, 1'b1, 3'b000, 3'b010, 32'hBAD0_0035);
    add(32'h0,   TrNonSeq, 1'b0, 3'b000, 3'b010, 32'h0);
    add(32'h34,  TrNonSeq, 1'b0, 3'b000, 3'b010, 32'h0);
    run_beats();

    // WRAP4 from 0x38, an extra 5th SEQ, then a wrap that jumps to 0x40.
    add(32'h38, TrNonSeq, 1'b1, 3'b010, 3'b010, 32'hC000_0038);
    add(32'h3C, TrSeq,    1'b1, 3'b010, 3'b010, 32'hC000_003C);
    add(32'h30, TrSeq,    1'b1, 3'b010, 3'b010, 32'hC000_0030);
    add(32'h34, TrSeq,    1'b1, 3'b010, 3'b010, 32'hC000_0034);
    add(32'h38, TrSeq,    1'b1, 3'b010, 3'b010, 32'hC500_0038);
    add(32'h38, TrNonSeq, 1'b1, 3'b010, 3'b010, 32'hD000_0038);
    add(32'h3C, TrSeq,    1'b1, 3'b010, 3'b010, 32'hD000_003C);
    add(32'h40, TrSeq,    1'b1, 3'b010, 3'b010, 32'hD000_0040);
    for (int j = 0; j < 5; j++)
      add(32'h30 + 32'(j * 4), TrNonSeq, 1'b0, 3'b000, 3'b010, 32'h0);
    run_beats();

    // Reset while a write to 0x50 sits in its wait states.
    tgt = 1; hsel0 = 1'b0; hsel2 = 1'b1;
    haddr = 32'h50; htrans = TrNonSeq; hwrite = 1'b1; hsize = 3'b010; hburst = 3'b000;
    @(posedge clk); #1;
    htrans = TrIdle; hwdata = 32'hDEAD_BEEF;
    check("wait_before_reset", 32'(hready2), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("reset_in_wait_hready", 32'(hready2), 32'd1);
    check("reset_in_wait_hresp", 32'(hresp2), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    add(32'h50, TrNonSeq, 1'b0, 3'b000, 3'b010, 32'h0);
    run_beats();

    // Random mix of singles, INCR4 bursts, illegal accesses and idle cycles.
    for (int t = 0; t < 2; t++) begin
      tgt = t;
      for (int i = 0; i < 30; i++) begin
        kind = int'($urandom_range(0, 5));
        w    = int'($urandom_range(0, 251));
        sub  = int'($urandom_range(0, 2));
        case (kind)
          0: add(32'(w * 4), TrNonSeq, 1'b1, 3'b000, 3'b010, $urandom);
          1: add(32'(w * 4), TrNonSeq, 1'b0, 3'b000, 3'b010, 32'h0);
          2, 3: begin
            for (int j = 0; j < 4; j++)
              add(32'((w + j) * 4), (j == 0) ? TrNonSeq : TrSeq, kind == 2, 3'b011, 3'b010,
                  $urandom);
          end
          4: begin
            if (sub == 0)      add(32'(w * 4 + 1), TrNonSeq, 1'b1, 3'b000, 3'b010, $urandom);
            else if (sub == 1) add(32'h400 + 32'(w * 4), TrNonSeq, 1'b0, 3'b000, 3'b010, 32'h0);
            else               add(32'(w * 4), TrNonSeq, 1'b1, 3'b000, 3'b000, $urandom);
          end
          default: add(32'h0, TrIdle, 1'b0, 3'b000, 3'b010, 32'h0);
        endcase
      end
      run_beats();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
